// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns PLL lock, raw reset buttons and a software request into NUM_OUT
//   staggered, synchronously released resets. It also reports the last
//   reset cause and a saturating count of reset requests.
//
// Ports
//   clk            single clock
//   reset_i        asynchronous active-high hard reset
//   locked_i       PLL lock (asynchronous, 2-FF synchronised)
//   btn_i          raw button pins (asynchronous, synchronised + debounced)
//   sw_reset_i     software reset request, synchronous to clk
//   reset_o        active-high resets, released in index order
//   ready_o        high once every reset_o bit is released
//   cause_o        last cause: 0 POR, 1 lock loss, 2 button, 3 software
//   reset_count_o  requests since reset_i, saturating at 255
//
// state      | meaning
// WAIT_LOCK  | all resets asserted, waiting for lock and no request
// HOLD       | lock stable, counting HOLD_CYCLES before release
// RELEASE    | dropping reset_o[k] every STAGGER_CYCLES
// RUN        | all resets released, ready_o high
module reset_sequencer #(
  parameter int NUM_OUT         = 4,
  parameter int NUM_BTN         = 1,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int HOLD_CYCLES     = 31,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               locked_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               sw_reset_i,
  output logic [NUM_OUT-1:0] reset_o,
  output logic               ready_o,
  output logic [1:0]         cause_o,
  output logic [7:0]         reset_count_o
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  // Value of reset_o on the RELEASE entry edge: only bit 0 dropped.
  localparam logic [NUM_OUT-1:0] FIRST_DROP = ~NUM_OUT'(1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  // Synchronisers. Buttons are normalised before synchronising so the
  // all-zero reset value means "released" regardless of pin polarity.
  logic               lock_meta_q, lock_s_q;
  logic [NUM_BTN-1:0] btn_norm, btn_meta_q, btn_sync_q;

  assign btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_i : btn_i;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
    end else begin
      lock_meta_q <= locked_i;
      lock_s_q    <= lock_meta_q;
      btn_meta_q  <= btn_norm;
      btn_sync_q  <= btn_meta_q;
    end
  end

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreeing cycle restarts the count.
  logic [NUM_BTN-1:0] btn_deb_q, btn_deb_d;
  logic [DW-1:0]      deb_cnt_q [NUM_BTN];
  logic [DW-1:0]      deb_cnt_d [NUM_BTN];

  always_comb begin
    btn_deb_d = btn_deb_q;
    deb_cnt_d = '{default: '0};
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_sync_q[i] != btn_deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) btn_deb_d[i] = ~btn_deb_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      btn_deb_q <= '0;
      deb_cnt_q <= '{default: '0};
    end else begin
      btn_deb_q <= btn_deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  logic btn_req, lock_req, any_req;
  assign btn_req  = |btn_deb_q;
  assign lock_req = ~lock_s_q;
  assign any_req  = lock_req | btn_req | sw_reset_i;

  state_t             state_q;
  logic [HW-1:0]      hold_cnt_q;
  logic [SW-1:0]      stag_cnt_q;
  logic [NUM_OUT-1:0] reset_q;
  logic               ready_q;
  logic [1:0]         cause_q;
  logic [7:0]         count_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_WAIT_LOCK;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      reset_q    <= '1;
      ready_q    <= 1'b0;
      cause_q    <= 2'd0;
      count_q    <= 8'd0;
    end else if (state_q == S_WAIT_LOCK) begin
      // A request that persists here is neither counted nor re-attributed.
      reset_q    <= '1;
      ready_q    <= 1'b0;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      if (!any_req) state_q <= S_HOLD;
    end else if (any_req) begin
      state_q    <= S_WAIT_LOCK;
      reset_q    <= '1;
      ready_q    <= 1'b0;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      if (lock_req)     cause_q <= 2'd1;
      else if (btn_req) cause_q <= 2'd2;
      else              cause_q <= 2'd3;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= S_RELEASE;
            reset_q    <= FIRST_DROP;
            stag_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          // Outputs drop low-index first, so a left shift releases the next one.
          if (reset_q == '0) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end else if (stag_cnt_q == STAG_LAST) begin
            reset_q    <= reset_q << 1;
            stag_cnt_q <= '0;
          end else begin
            stag_cnt_q <= stag_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          reset_q <= '0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_WAIT_LOCK;
      endcase
    end
  end

  assign reset_o       = reset_q;
  assign ready_o       = ready_q;
  assign cause_o       = cause_q;
  assign reset_count_o = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int H = 31;
  localparam int S = 16;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       locked_i = 1'b1;
  logic [0:0] btn_i = 1'b1;
  logic       sw_reset_i = 1'b0;
  logic [3:0] reset_o;
  logic       ready_o;
  logic [1:0] cause_o;
  logic [7:0] reset_count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t e;

  reset_sequencer #(
    .NUM_OUT(4), .NUM_BTN(1), .BTN_ACTIVE_LOW(1),
    .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .locked_i(locked_i),
    .btn_i(btn_i),
    .sw_reset_i(sw_reset_i),
    .reset_o(reset_o),
    .ready_o(ready_o),
    .cause_o(cause_o),
    .reset_count_o(reset_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(int c, logic [3:0] r, logic y);
    exp_t x;
    x.cyc = c;
    x.rst = r;
    x.rdy = y;
    q.push_back(x);
  endfunction

  // Expected release sequence given the edge e2 on which HOLD is entered.
  function automatic void push_release(int e2);
    logic [3:0] m;
    m = 4'hF;
    push_exp(e2 + H - 1, m, 1'b0);
    for (int k = 0; k < 4; k++) begin
      m = m << 1;
      push_exp(e2 + H + k * S, m, 1'b0);
      if (k < 3) push_exp(e2 + H + (k + 1) * S - 1, m, 1'b0);
    end
    push_exp(e2 + H + 3 * S + 1, 4'h0, 1'b1);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (reset_o !== 4'hF || ready_o !== 1'b0 || cause_o !== 2'd0 || reset_count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state got rst=%h rdy=%b cause=%0d cnt=%0d want rst=f rdy=0 cause=0 cnt=0",
               reset_o, ready_o, cause_o, reset_count_o);
    end
  endtask

  task automatic test_powerup();
    int t;
    reset_i = 1'b0;
    t = cyc;
    push_release(t + 3);
    for (int b = 0; b < 200 && q.size() != 0; b++) begin
      tick();
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL powerup cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL powerup timeout, %0d expectations left", q.size());
      q.delete();
    end
    n_tests++;
    if (cause_o !== 2'd0 || reset_count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL powerup_status got cause=%0d cnt=%0d want cause=0 cnt=0", cause_o, reset_count_o);
    end
  endtask

  task automatic test_lock_loss();
    int t;
    tick(); tick();
    locked_i = 1'b0;
    t = cyc;
    push_exp(t + 2, 4'h0, 1'b1);
    push_exp(t + 3, 4'hF, 1'b0);
    for (int k = 4; k < 10; k++) push_exp(t + k, 4'hF, 1'b0);
    for (int b = 0; b < 50 && q.size() != 0; b++) begin
      tick();
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL lock_loss cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL lock_loss timeout, %0d expectations left", q.size());
      q.delete();
    end
    n_tests++;
    if (cause_o !== 2'd1 || reset_count_o !== 8'd1) begin
      n_fail++;
      $display("FAIL lock_loss_status got cause=%0d cnt=%0d want cause=1 cnt=1", cause_o, reset_count_o);
    end
    locked_i = 1'b1;
    t = cyc;
    push_release(t + 3);
    for (int b = 0; b < 200 && q.size() != 0; b++) begin
      tick();
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL relock cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL relock timeout, %0d expectations left", q.size());
      q.delete();
    end
  endtask

  task automatic test_button();
    int t;
    tick();
    t = cyc;
    // Bounce for 24 edges, then a stable press from edge t+25; the press
    // reaches the FSM 2 + D + 1 edges later (t+35).
    for (int k = 1; k <= 34; k++) push_exp(t + k, 4'h0, 1'b1);
    for (int k = 35; k <= 60; k++) push_exp(t + k, 4'hF, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      if (k <= 24) btn_i = (((k - 1) % 6) < 5) ? 1'b0 : 1'b1;
      else         btn_i = 1'b0;
      tick();
      if (q.size() != 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL button cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL button timeout, %0d expectations left", q.size());
      q.delete();
    end
    n_tests++;
    if (cause_o !== 2'd2 || reset_count_o !== 8'd2) begin
      n_fail++;
      $display("FAIL button_status got cause=%0d cnt=%0d want cause=2 cnt=2", cause_o, reset_count_o);
    end
    btn_i = 1'b1;
    t = cyc;
    push_release(t + 11);
    for (int b = 0; b < 200 && q.size() != 0; b++) begin
      tick();
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL button_release cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL button_release timeout, %0d expectations left", q.size());
      q.delete();
    end
  endtask

  task automatic test_sw_release();
    int t;
    tick(); tick();
    sw_reset_i = 1'b1;
    t = cyc;
    push_exp(t + 1, 4'hF, 1'b0);
    push_exp(t + 2 + H - 1, 4'hF, 1'b0);
    push_exp(t + 2 + H, 4'hE, 1'b0);
    for (int b = 0; b < 100 && q.size() != 0; b++) begin
      tick();
      sw_reset_i = 1'b0;
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL sw_run cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sw_run timeout, %0d expectations left", q.size());
      q.delete();
    end
    n_tests++;
    if (cause_o !== 2'd3 || reset_count_o !== 8'd3) begin
      n_fail++;
      $display("FAIL sw_run_status got cause=%0d cnt=%0d want cause=3 cnt=3", cause_o, reset_count_o);
    end
    for (int i = 0; i < 4; i++) tick();
    sw_reset_i = 1'b1;
    t = cyc;
    push_exp(t + 1, 4'hF, 1'b0);
    push_release(t + 2);
    for (int b = 0; b < 200 && q.size() != 0; b++) begin
      tick();
      sw_reset_i = 1'b0;
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL sw_release cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sw_release timeout, %0d expectations left", q.size());
      q.delete();
    end
    n_tests++;
    if (cause_o !== 2'd3 || reset_count_o !== 8'd4) begin
      n_fail++;
      $display("FAIL sw_release_status got cause=%0d cnt=%0d want cause=3 cnt=4", cause_o, reset_count_o);
    end
  endtask

  task automatic test_simultaneous();
    int t;
    tick(); tick();
    locked_i = 1'b0;
    t = cyc;
    push_exp(t + 2, 4'h0, 1'b1);
    push_exp(t + 3, 4'hF, 1'b0);
    for (int k = 4; k < 8; k++) push_exp(t + k, 4'hF, 1'b0);
    for (int b = 0; b < 30 && q.size() != 0; b++) begin
      tick();
      // lock loss reaches the FSM at t+3, so the software pulse is aimed there too
      sw_reset_i = (cyc == t + 2);
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL simultaneous cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    sw_reset_i = 1'b0;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL simultaneous timeout, %0d expectations left", q.size());
      q.delete();
    end
    n_tests++;
    if (cause_o !== 2'd1 || reset_count_o !== 8'd5) begin
      n_fail++;
      $display("FAIL simultaneous_status got cause=%0d cnt=%0d want cause=1 cnt=5", cause_o, reset_count_o);
    end
    locked_i = 1'b1;
    t = cyc;
    push_release(t + 3);
    for (int b = 0; b < 200 && q.size() != 0; b++) begin
      tick();
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        if (reset_o !== e.rst || ready_o !== e.rdy) begin
          n_fail++;
          $display("FAIL simultaneous_relock cyc=%0d got rst=%h rdy=%b want rst=%h rdy=%b", cyc, reset_o, ready_o, e.rst, e.rdy);
        end
      end
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL simultaneous_relock timeout, %0d expectations left", q.size());
      q.delete();
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    exp_cnt = 5;
    for (int i = 0; i < 300; i++) begin
      sw_reset_i = 1'b1;
      tick();
      sw_reset_i = 1'b0;
      if (exp_cnt < 255) exp_cnt++;
      for (int b = 0; b < 200 && !ready_o; b++) tick();
      if (!ready_o) begin
        n_fail++;
        $display("FAIL saturation_ready timeout at pulse %0d", i);
        break;
      end
      if (i == 100 || i == 249 || i == 299) begin
        n_tests++;
        if (reset_count_o !== 8'(exp_cnt) || cause_o !== 2'd3) begin
          n_fail++;
          $display("FAIL saturation pulse=%0d got cnt=%0d cause=%0d want cnt=%0d cause=3",
                   i, reset_count_o, cause_o, exp_cnt);
        end
      end
    end
    tick();
    reset_i = 1'b1;
    #1;
    n_tests++;
    if (reset_o !== 4'hF || ready_o !== 1'b0 || cause_o !== 2'd0 || reset_count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset got rst=%h rdy=%b cause=%0d cnt=%0d want rst=f rdy=0 cause=0 cnt=0",
               reset_o, ready_o, cause_o, reset_count_o);
    end
    tick(); tick();
    reset_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_lock_loss();
    test_button();
    test_sw_release();
    test_simultaneous();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset controller. It turns PLL lock, raw board buttons and a software request into NUM_OUT staggered, synchronous-release reset outputs for the clock domain's subsystems (SoC core, SDRAM controller, video, USB/PS/2 glue). It generalises the fixed power-on hold counter with:
- lock-loss re-entry
- per-button debounce
- a software reset request
- staggered release
- cause and count reporting

Parameters:
NUM_OUT, 4, number of reset outputs, released in index order
NUM_BTN, 1, number of raw reset buttons
BTN_ACTIVE_LOW, 1, 1 = button pressed when pin low
HOLD_CYCLES, 31, cycles lock must stay stable before release starts (>=1)
STAGGER_CYCLES, 16, cycles between successive output releases (>=1)
DEBOUNCE_CYCLES, 1024, consecutive stable cycles for a debounced button change (>=2)

Ports:
clk  in  1  single clock
reset_i  in  1  asynchronous, active-high hard reset
locked_i  in  1  PLL lock, asynchronous to clk
btn_i  in  NUM_BTN  raw button pins, asynchronous
sw_reset_i  in  1  software request, synchronous to clk, level or pulse
reset_o  out  NUM_OUT  active-high resets, registered
ready_o  out  1  high when all outputs are released
cause_o  out  2  last reset cause: 0 POR, 1 lock loss, 2 button, 3 software
reset_count_o  out  8  requests since reset_i, saturates at 255

Behaviour:
- Clock and reset: reset_i is asynchronous and active-high. While reset_i is high:
  - state = WAIT_LOCK; reset_o = all ones; ready_o = 0; cause_o = 0; reset_count_o = 0.
  - All counters = 0; synchronisers = 0; debounced buttons = released.
- Synchronisers:
  - locked_i and each btn_i pass through a 2-FF synchroniser, giving 2 cycles of latency. sw_reset_i is not synchronised.
  - Button polarity is normalised by BTN_ACTIVE_LOW: pressed = 1 internally.
- Debounce, per button:
  - The counter increments while the synced value differs from the debounced state, and clears when they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
  - btn_req = OR of all debounced pressed states.
- FSM states: WAIT_LOCK, HOLD, RELEASE, RUN.
  - WAIT_LOCK: reset_o all ones. Go to HOLD when lock_s=1, btn_req=0 and sw_reset_i=0; the hold counter clears.
  - HOLD: the counter increments each cycle. At count HOLD_CYCLES-1, go to RELEASE on the next edge.
  - RELEASE:
    - reset_o[0] drops on the entry edge.
    - reset_o[k] drops k*STAGGER_CYCLES edges after entry.
    - Once reset_o[k] drops it stays low until a request.
    - The edge after reset_o[NUM_OUT-1] drops: go to RUN and set ready_o = 1.
  - RUN: hold reset_o = 0 and ready_o = 1.
- Requests: lock_s=0, btn_req=1 or sw_reset_i=1.
  - A request in HOLD, RELEASE or RUN forces state = WAIT_LOCK on that edge.
  - On that same edge: reset_o = all ones, ready_o = 0, HOLD/stagger counters clear, reset_count_o increments (saturating), cause_o updates.
  - A request that persists in WAIT_LOCK is not counted again.
  - Priority when requests coincide: lock loss > button > software.
- Latency:
  - sw_reset_i sampled high at edge E: reset_o all ones from E.
  - locked_i low sampled at edge E: reset_o all ones from E+2.
  - Button press: 2 + DEBOUNCE_CYCLES edges, then 1 edge to the FSM.
- Power-up timing: let E0 be the first edge sampling locked_i=1 (buttons released).
  - lock_s=1 after E1; HOLD entered at E2.
  - reset_o[k] drops at E2 + HOLD_CYCLES + k*STAGGER_CYCLES.
  - ready_o rises one edge after the last drop.
- Boundaries:
  - Holding a button or sw_reset_i keeps the block in WAIT_LOCK indefinitely.
  - A lock glitch shorter than one cycle may be missed; this is accepted.
  - Bounce shorter than DEBOUNCE_CYCLES is never reported.
  - With NUM_OUT=1, RUN is entered the edge after RELEASE entry.
  - reset_i asserted mid-sequence returns everything to reset values immediately.

Test Plan:
- Power-up, defaults: reset_i high 5 cycles, then low, locked_i=1 from E0 → reset_o[0..3] drop at E33/E49/E65/E81; ready_o=1 at E82; cause_o=0; reset_count_o=0.
- Lock loss in RUN: locked_i low at edge E → reset_o=4'hF at E+2; ready_o=0; cause_o=1; count=1. Relock → release sequence restarts with identical spacing.
- Bouncing button in RUN (DEBOUNCE_CYCLES=8): btn low 5 cycles, high 1, repeated 4 times → no reset. Then btn low 10 cycles → reset_o all ones at 2+8+1 edges after the stable low began; cause_o=2. Held low → stays in WAIT_LOCK.
- Software pulse during RELEASE (after reset_o[0] dropped): sw_reset_i high 1 cycle at E → reset_o=4'hF at E; cause_o=3; count increments; full sequence restarts.
- Simultaneous sw_reset_i and lock loss: both seen on the same edge → cause_o=1; count increments by exactly 1.
- Saturation: 300 software pulses, each after ready_o → reset_count_o=255. Then assert reset_i → count=0, cause_o=0, reset_o all ones.
